// File: rtl/axis_pattern_gen_multi.sv
// Multi-mode AXI4-Stream test-pattern source: counter, LFSR, walking-one or constant beats
// generated on a programmable rate tick, framed with TLAST and buffered in a small FIFO.
module axis_pattern_gen_multi #(
    parameter int          TDATA_WIDTH   = 32,
    parameter int          COUNTER_START = 0,
    parameter int          COUNTER_END   = 255,
    parameter int          COUNTER_INCR  = 1,
    parameter logic [31:0] LFSR_SEED     = 32'h1,
    parameter logic [31:0] PATTERN_CONST = 32'hA5A5A5A5,
    parameter int          DIV_WIDTH     = 16,
    parameter int          LEN_WIDTH     = 16,
    parameter int          FIFO_DEPTH    = 4
) (
    input  logic                   m_axis_aclk,
    input  logic                   m_axis_aresetn,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [DIV_WIDTH-1:0]   divider,
    input  logic [LEN_WIDTH-1:0]   pkt_len,
    input  logic                   drop_clr,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    output logic [15:0]            drop_count
);

    localparam int W  = TDATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [W-1:0]  C_START = W'(COUNTER_START);
    localparam logic [W-1:0]  C_END   = W'(COUNTER_END);
    localparam logic [W-1:0]  C_INCR  = W'(COUNTER_INCR);
    localparam logic [W-1:0]  C_CONST = W'({32'b0, PATTERN_CONST});
    localparam logic [31:0]   LFSR_TAPS = 32'h8020_0003;

    // Rate divider
    logic [DIV_WIDTH-1:0] divcnt;
    logic                 tick;

    assign tick = enable && (divcnt == '0);

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            divcnt <= '0;
        end else if (tick) begin
            divcnt <= divider;
        end else if (enable) begin
            divcnt <= divcnt - DIV_WIDTH'(1);
        end
    end

    // Generator and framing state
    logic [1:0]           act_mode;
    logic [LEN_WIDTH-1:0] act_len;
    logic [LEN_WIDTH-1:0] beat_idx;
    logic [W-1:0]         cnt_q;
    logic [31:0]          lfsr_q;
    logic [W-1:0]         walk_q;

    logic                 pkt_start;
    logic                 reinit;
    logic [1:0]           eff_mode;
    logic [LEN_WIDTH-1:0] eff_len;
    logic [W-1:0]         cnt_cur, cnt_next;
    logic [31:0]          lfsr_cur, lfsr_next;
    logic [W-1:0]         walk_cur, walk_next;
    logic [W-1:0]         beat_data;
    logic                 beat_last;
    logic [LEN_WIDTH-1:0] idx_next;

    always_comb begin
        pkt_start = tick && (beat_idx == '0);
        eff_mode  = pkt_start ? mode : act_mode;
        eff_len   = pkt_start ? pkt_len : act_len;
        // Switching mode at a packet boundary restarts the new pattern from its seed.
        reinit    = pkt_start && (mode != act_mode);

        cnt_cur  = (reinit && mode == 2'd0) ? C_START   : cnt_q;
        lfsr_cur = (reinit && mode == 2'd1) ? LFSR_SEED : lfsr_q;
        walk_cur = (reinit && mode == 2'd2) ? W'(1)     : walk_q;

        case (eff_mode)
            2'd0:    beat_data = cnt_cur;
            2'd1:    beat_data = W'({32'b0, lfsr_cur});
            2'd2:    beat_data = walk_cur;
            default: beat_data = C_CONST;
        endcase

        beat_last = (eff_len != '0) && (beat_idx == eff_len - LEN_WIDTH'(1));
        idx_next  = (beat_last || eff_len == '0) ? '0 : beat_idx + LEN_WIDTH'(1);

        cnt_next  = (cnt_cur >= C_END) ? cnt_cur - (C_END - C_START) : cnt_cur + C_INCR;
        lfsr_next = lfsr_cur[0] ? ((lfsr_cur >> 1) ^ LFSR_TAPS) : (lfsr_cur >> 1);
        walk_next = {walk_cur[W-2:0], walk_cur[W-1]};
    end

    // Every generator advances on every tick, whether or not the beat fits in the FIFO.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            act_mode <= 2'd0;
            act_len  <= '0;
            beat_idx <= '0;
            cnt_q    <= C_START;
            lfsr_q   <= LFSR_SEED;
            walk_q   <= W'(1);
        end else if (tick) begin
            if (pkt_start) begin
                act_mode <= mode;
                act_len  <= pkt_len;
            end
            beat_idx <= idx_next;
            cnt_q    <= cnt_next;
            lfsr_q   <= lfsr_next;
            walk_q   <= walk_next;
        end
    end

    // Output FIFO. Handshake: tvalid is high exactly while the FIFO holds a beat, the head
    // beat is held unchanged until tvalid&tready, and that cycle pops it.
    logic [W:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;
    logic        push, pop, drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && m_axis_tready;
    assign push       = tick && (!fifo_full || pop);
    assign drop       = tick && fifo_full && !pop;

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[AW-1:0]] <= {beat_last, beat_data};
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_mem[rd_ptr[AW-1:0]][W-1:0];
    assign m_axis_tlast  = fifo_mem[rd_ptr[AW-1:0]][W];

    // A clear coinciding with a drop keeps that drop.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            drop_count <= '0;
        end else if (drop_clr) begin
            drop_count <= drop ? 16'd1 : 16'd0;
        end else if (drop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_axis_pattern_gen_multi.sv
// Bench for axis_pattern_gen_multi: directed scenarios plus randomized traffic, all checked
// against a beat-level reference model holding the expected FIFO contents in a queue.
module tb_axis_pattern_gen_multi;

    localparam int          W        = 32;
    localparam int          DEPTH    = 4;
    localparam longint      C_START  = 0;
    localparam longint      C_END    = 255;
    localparam longint      C_INCR   = 1;
    localparam logic [31:0] SEED     = 32'h1;
    localparam logic [31:0] CONST    = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] divider;
    logic [15:0] pkt_len;
    logic        drop_clr;
    logic        tready;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    // Clock and DUT
    always #5 clk = ~clk;

    axis_pattern_gen_multi #(
        .TDATA_WIDTH(W), .COUNTER_START(0), .COUNTER_END(255), .COUNTER_INCR(1),
        .LFSR_SEED(SEED), .PATTERN_CONST(CONST), .DIV_WIDTH(16), .LEN_WIDTH(16),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .m_axis_aclk(clk), .m_axis_aresetn(aresetn), .enable(enable), .mode(mode),
        .divider(divider), .pkt_len(pkt_len), .drop_clr(drop_clr),
        .m_axis_tready(tready), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tlast(tlast), .drop_count(drop_count)
    );

    // Reference model state
    logic [W:0]  exp_q[$];
    logic [W:0]  obs_q[$];
    int          m_div;
    int          m_idx;
    int          m_act_mode;
    int          m_act_len;
    longint      m_cnt;
    logic [31:0] m_lfsr;
    int          m_walk_pos;
    int          m_drops;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W:0] obs_at(input int i);
        if (obs_q.size() > i) return obs_q[i];
        return {1'b1, 32'hDEAD_BEEF};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        obs_q.delete();
        m_div = 0; m_idx = 0; m_act_mode = 0; m_act_len = 0;
        m_cnt = C_START; m_lfsr = SEED; m_walk_pos = 0; m_drops = 0;
    endtask

    // One generated beat following the pattern and framing rules.
    task automatic gen_beat(output logic [W:0] b);
        logic [31:0] d;
        logic        last;
        if (m_idx == 0) begin
            if (int'(mode) != m_act_mode) begin
                case (int'(mode))
                    0: m_cnt = C_START;
                    1: m_lfsr = SEED;
                    2: m_walk_pos = 0;
                    default: ;
                endcase
            end
            m_act_mode = int'(mode);
            m_act_len  = int'(pkt_len);
        end
        case (m_act_mode)
            0: d = 32'(m_cnt);
            1: d = m_lfsr;
            2: d = 32'h1 << m_walk_pos;
            default: d = CONST;
        endcase
        last = (m_act_len != 0) && (m_idx == m_act_len - 1);
        b = {last, d};
        if (m_cnt >= C_END) m_cnt = m_cnt - (C_END - C_START);
        else m_cnt = (m_cnt + C_INCR) % 64'h1_0000_0000;
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
        m_walk_pos = (m_walk_pos + 1) % W;
        m_idx = (last || m_act_len == 0) ? 0 : m_idx + 1;
    endtask

    // Called at a falling edge with inputs already set: check outputs, step model, advance.
    task automatic cycle();
        bit         pop, full, tick, drop;
        logic [W:0] b;
        check("tvalid", 64'(tvalid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("tdata", 64'(tdata), 64'(exp_q[0][W-1:0]));
            check("tlast", 64'(tlast), 64'(exp_q[0][W]));
        end
        check("drop_count", 64'(drop_count), 64'(m_drops));
        if (tvalid && tready) obs_q.push_back({tlast, tdata});

        full = (exp_q.size() == DEPTH);
        pop  = (exp_q.size() != 0) && tready;
        if (pop) void'(exp_q.pop_front());
        tick = 0;
        if (enable) begin
            if (m_div == 0) begin
                tick  = 1;
                m_div = int'(divider);
            end else begin
                m_div--;
            end
        end
        drop = 0;
        if (tick) begin
            gen_beat(b);
            if (!full || pop) exp_q.push_back(b);
            else drop = 1;
        end
        if (drop_clr) m_drops = drop ? 1 : 0;
        else if (drop && m_drops < 65535) m_drops++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_drops", 64'(drop_count), 64'd0);
        model_reset();
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    task automatic set_cfg(input bit en, input int md, input int dv, input int ln, input bit rdy);
        enable = en; mode = 2'(md); divider = 16'(dv); pkt_len = 16'(ln); tready = rdy;
        drop_clr = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        do_reset();

        // Counter, one beat per cycle, packets of 4, wrap at 255
        set_cfg(1, 0, 0, 4, 1);
        repeat (262) cycle();
        check("t1_beat2_last", 64'(obs_at(2)), {31'd0, 1'b0, 32'd2});
        check("t1_beat3_last", 64'(obs_at(3)), {31'd0, 1'b1, 32'd3});
        check("t1_beat255", 64'(obs_at(255)), {31'd0, 1'b1, 32'd255});
        check("t1_wrap", 64'(obs_at(256)), {31'd0, 1'b0, 32'd0});

        // Divider 4: one beat per 5 cycles
        do_reset();
        set_cfg(1, 0, 4, 0, 1);
        repeat (50) cycle();
        check("t2_beat_count", 64'(obs_q.size()), 64'd10);

        // Back-pressure overflow
        do_reset();
        set_cfg(1, 0, 0, 0, 0);
        repeat (20) cycle();
        check("t3_drops", 64'(drop_count), 64'd16);
        check("t3_held", 64'(tdata), 64'd0);
        tready = 1'b1;
        repeat (10) cycle();
        check("t3_b0", 64'(obs_at(0)), 64'd0);
        check("t3_b3", 64'(obs_at(3)), 64'd3);
        check("t3_b4", 64'(obs_at(4)), 64'd20);
        check("t3_b5", 64'(obs_at(5)), 64'd21);

        // Mode change mid-packet takes effect at the next packet
        do_reset();
        set_cfg(1, 0, 0, 8, 1);
        repeat (4) cycle();
        mode = 2'd2;
        repeat (20) cycle();
        check("t4_b6", 64'(obs_at(6)), 64'd6);
        check("t4_b7", 64'(obs_at(7)), {31'd0, 1'b1, 32'd7});
        check("t4_b8", 64'(obs_at(8)), 64'h1);
        check("t4_b9", 64'(obs_at(9)), 64'h2);
        check("t4_b10", 64'(obs_at(10)), 64'h4);

        // LFSR unframed, with an enable gap
        do_reset();
        set_cfg(1, 1, 0, 0, 1);
        repeat (5) cycle();
        check("t5_b0", 64'(obs_at(0)), 64'h0000_0001);
        check("t5_b1", 64'(obs_at(1)), 64'h8020_0003);
        check("t5_b2", 64'(obs_at(2)), 64'hC030_0002);
        enable = 1'b0;
        repeat (10) cycle();
        enable = 1'b1;
        repeat (10) cycle();

        // drop_clr coincident with a drop, then reset mid-packet
        do_reset();
        set_cfg(1, 0, 0, 0, 0);
        repeat (6) cycle();
        drop_clr = 1'b1;
        cycle();
        drop_clr = 1'b0;
        check("t6_clr_drop", 64'(drop_count), 64'd1);
        set_cfg(1, 0, 0, 5, 1);
        repeat (8) cycle();
        do_reset();
        set_cfg(1, 0, 0, 5, 1);
        repeat (10) cycle();
        check("t6_restart_b0", 64'(obs_at(0)), 64'd0);
        check("t6_restart_b4", 64'(obs_at(4)), {31'd0, 1'b1, 32'd4});

        // Randomized traffic
        do_reset();
        set_cfg(1, 0, 0, 3, 1);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                mode    = 2'($urandom_range(0, 3));
                pkt_len = 16'($urandom_range(0, 9));
                divider = 16'($urandom_range(0, 3));
            end
            enable   = ($urandom_range(0, 9) != 0);
            tready   = ($urandom_range(0, 3) != 0);
            drop_clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 799) == 0) do_reset();
            else cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
